// File: rtl/router_pkg.sv
// Shared definitions for the 5-port, 2-VC NoC router allocators.
// Contents: default port/VC counts, flit width, port index constants,
// VC id type, per-VC wormhole lock state enum, round-robin pointer helper.
package router_pkg;

  localparam int unsigned NPORT  = 5;
  localparam int unsigned NVC    = 2;
  localparam int unsigned FLIT_W = 35;

  localparam int unsigned P_LOCAL = 0;
  localparam int unsigned P_NORTH = 1;
  localparam int unsigned P_EAST  = 2;
  localparam int unsigned P_SOUTH = 3;
  localparam int unsigned P_WEST  = 4;

  localparam int unsigned VC_ID_W = (NVC > 1) ? $clog2(NVC) : 1;
  typedef logic [VC_ID_W-1:0] vc_id_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } lock_state_e;

  // Next round-robin start position after index idx has been served.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/router_out_arb_if.sv
// Handshake/bus bundle between the input ports and one output allocator.
//   REQ/REQ_VC/REQ_TAIL : per-input head-of-line flit request, VC and tail flag
//   IACK                : downstream per-VC credit return pulses
//   GNT                 : one-hot combinational grant (flit consumed at edge)
//   OSEL/OVALID/OVCH    : registered crossbar select, link valid and VC
//   OLCK                : registered per-VC lock status
//   CRED_ERR            : sticky credit-overflow flag
// Modports: master = requesters/downstream side, slave = allocator.
interface router_out_arb_if #(
  parameter int unsigned NPORT = 5,
  parameter int unsigned NVC   = 2
);
  localparam int unsigned VCW  = (NVC > 1) ? $clog2(NVC) : 1;
  localparam int unsigned SELW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0]     REQ;
  logic [NPORT*VCW-1:0] REQ_VC;
  logic [NPORT-1:0]     REQ_TAIL;
  logic [NVC-1:0]       IACK;
  logic [NPORT-1:0]     GNT;
  logic [SELW-1:0]      OSEL;
  logic                 OVALID;
  logic [VCW-1:0]       OVCH;
  logic [NVC-1:0]       OLCK;
  logic                 CRED_ERR;

  modport master (
    output REQ, REQ_VC, REQ_TAIL, IACK,
    input  GNT, OSEL, OVALID, OVCH, OLCK, CRED_ERR
  );

  modport slave (
    input  REQ, REQ_VC, REQ_TAIL, IACK,
    output GNT, OSEL, OVALID, OVCH, OLCK, CRED_ERR
  );
endinterface

// File: rtl/rr_arb.sv
// Combinational N-way round-robin priority picker.
//   i_elig : eligible request vector
//   i_ptr  : index with highest priority this cycle
//   o_gnt  : one-hot grant (all zero if nothing eligible)
//   o_idx  : encoded index of the granted input (0 if none)
//   o_any  : a grant was issued
module rr_arb
  import router_pkg::*;
#(
  parameter  int unsigned N    = 5,
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_elig,
  input  logic [SELW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);

  int unsigned     w_pos;
  logic [SELW-1:0] w_sel;

  // Scan from i_ptr upward with wrap; the first eligible index wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    w_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_sel = SELW'(w_pos);
      if (!o_any && i_elig[w_sel]) begin
        o_any        = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/router_out_arb.sv
// Per-output-port switch allocator: round-robin over head-of-line flits,
// wormhole lock per output VC, downstream credit tracking per VC.
// Ports:
//   clk       : clock
//   RST       : asynchronous active-high reset
//   bus       : router_out_arb_if.slave (REQ/REQ_VC/REQ_TAIL/IACK in,
//               GNT/OSEL/OVALID/OVCH/OLCK/CRED_ERR out)
//   STALL_CNT : 16-bit saturating stall counter, present only when
//               ROUTER_ARB_STALL_CNT_EN is defined
module router_out_arb
  import router_pkg::*;
#(
  parameter  int unsigned NPORT      = 5,
  parameter  int unsigned NVC        = 2,
  parameter  int unsigned CRED_DEPTH = 4,
  localparam int unsigned VCW        = (NVC > 1) ? $clog2(NVC) : 1,
  localparam int unsigned SELW       = (NPORT > 1) ? $clog2(NPORT) : 1,
  localparam int unsigned CW         = $clog2(CRED_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            RST,
  router_out_arb_if.slave bus
`ifdef ROUTER_ARB_STALL_CNT_EN
  ,
  output logic [15:0]     STALL_CNT
`endif
);

  logic [VCW-1:0]   w_vc [NPORT];
  logic [NPORT-1:0] w_elig;
  logic [NPORT-1:0] w_gnt;
  logic [SELW-1:0]  w_gidx;
  logic             w_any;
  logic [VCW-1:0]   w_gvc;
  logic             w_gtail;
  logic [NVC-1:0]   w_vc_gnt;
  logic [NVC-1:0]   w_olck;

  lock_state_e      r_lock      [NVC];
  lock_state_e      w_lock_nxt  [NVC];
  logic [SELW-1:0]  r_owner     [NVC];
  logic [SELW-1:0]  w_owner_nxt [NVC];
  logic [CW-1:0]    r_cred      [NVC];

  logic [SELW-1:0]  r_rr_ptr;
  logic [SELW-1:0]  r_osel;
  logic             r_ovalid;
  logic [VCW-1:0]   r_ovch;
  logic             r_cred_err;

  // Eligibility: request present, legal VC, credit available, and the VC is
  // either unlocked or locked to this very input.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      w_vc[i] = bus.REQ_VC[i*VCW +: VCW];
      if (bus.REQ[i] && (32'(w_vc[i]) < NVC)) begin
        if ((r_cred[w_vc[i]] != '0) &&
            ((r_lock[w_vc[i]] == ARB_IDLE) || (r_owner[w_vc[i]] == SELW'(i))))
          w_elig[i] = 1'b1;
      end
    end
  end

  rr_arb #(.N(NPORT)) u_rr_arb (
    .i_elig (w_elig),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx),
    .o_any  (w_any)
  );

  always_comb begin
    w_gvc   = w_vc[w_gidx];
    w_gtail = bus.REQ_TAIL[w_gidx];
    for (int unsigned v = 0; v < NVC; v++) begin
      w_vc_gnt[v] = w_any && (w_gvc == VCW'(v));
    end
  end

  // Per-VC wormhole lock FSM. A granted flit on a locked VC is necessarily
  // from the owner, so the tail check needs no owner comparison.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int unsigned v = 0; v < NVC; v++) begin
        r_lock[v]  <= ARB_IDLE;
        r_owner[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NVC; v++) begin
        r_lock[v]  <= w_lock_nxt[v];
        r_owner[v] <= w_owner_nxt[v];
      end
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < NVC; v++) begin
      w_lock_nxt[v]  = r_lock[v];
      w_owner_nxt[v] = r_owner[v];
      if (w_vc_gnt[v]) begin
        unique case (r_lock[v])
          ARB_IDLE: begin
            if (!w_gtail) begin
              w_lock_nxt[v]  = ARB_LOCKED;
              w_owner_nxt[v] = w_gidx;
            end
          end
          ARB_LOCKED: begin
            if (w_gtail) w_lock_nxt[v] = ARB_IDLE;
          end
          default: w_lock_nxt[v] = ARB_IDLE;
        endcase
      end
    end
  end

  // Credits: grant and IACK on the same VC cancel; IACK at full credit
  // saturates and raises the sticky error.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int unsigned v = 0; v < NVC; v++) r_cred[v] <= CW'(CRED_DEPTH);
      r_cred_err <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NVC; v++) begin
        if (w_vc_gnt[v] && !bus.IACK[v]) begin
          r_cred[v] <= r_cred[v] - CW'(1);
        end else if (bus.IACK[v] && !w_vc_gnt[v]) begin
          if (r_cred[v] == CW'(CRED_DEPTH)) r_cred_err <= 1'b1;
          else                              r_cred[v]  <= r_cred[v] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_rr_ptr <= '0;
      r_osel   <= '0;
      r_ovalid <= 1'b0;
      r_ovch   <= '0;
    end else begin
      r_ovalid <= w_any;
      if (w_any) begin
        r_rr_ptr <= SELW'(rr_next(32'(w_gidx), NPORT));
        r_osel   <= w_gidx;
        r_ovch   <= w_gvc;
      end
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < NVC; v++) begin
      w_olck[v] = (r_lock[v] == ARB_LOCKED);
    end
  end

  assign bus.GNT      = w_gnt;
  assign bus.OSEL     = r_osel;
  assign bus.OVALID   = r_ovalid;
  assign bus.OVCH     = r_ovch;
  assign bus.OLCK     = w_olck;
  assign bus.CRED_ERR = r_cred_err;

`ifdef ROUTER_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if ((|bus.REQ) && !w_any && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign STALL_CNT = r_stall_cnt;
`endif

endmodule
